// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: widths, op encodings, flag bit positions.
package alu_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SHAMT_W = 4;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned FLAGS_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_ANDN = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL  = 3'b100;
  localparam logic [OP_W-1:0] OP_SLL  = 3'b101;
  localparam logic [OP_W-1:0] OP_ROR  = 3'b110;
  localparam logic [OP_W-1:0] OP_SRA  = 3'b111;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: adder, barrel shifter and logic ops producing result and {Z,N,V,C}.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   r,
  output logic [FLAGS_W-1:0] flags
);

  localparam int unsigned      SUM_W   = WIDTH + 1;
  localparam logic [SHAMT_W:0] FULL_SH = (SHAMT_W+1)'(WIDTH);

  logic               is_sub;
  logic [WIDTH-1:0]   b_eff;
  logic [SUM_W-1:0]   sum;
  logic [WIDTH-1:0]   xor_y;
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W:0]   inv_sh;
  logic [WIDTH-1:0]   rol_y;
  logic [WIDTH-1:0]   ror_y;
  logic [WIDTH-1:0]   sll_y;
  logic [WIDTH-1:0]   sra_y;
  logic               v_c;
  logic               c_c;

  alu_xor16 u_xor (
    .a (a),
    .b (b),
    .y (xor_y)
  );

  // Shared adder: subtraction is A + ~B + 1, carry-out means no borrow.
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + SUM_W'(is_sub);

  // Barrel shifter; a shift of WIDTH yields zero, so rotate-by-0 returns A.
  assign shamt  = b[SHAMT_W-1:0];
  assign inv_sh = FULL_SH - {1'b0, shamt};
  assign rol_y  = (a << shamt) | (a >> inv_sh);
  assign ror_y  = (a >> shamt) | (a << inv_sh);
  assign sll_y  = a << shamt;
  assign sra_y  = $signed(a) >>> shamt;

  // Result select and V/C generation.
  always_comb begin
    r   = '0;
    v_c = 1'b0;
    c_c = 1'b0;
    case (op)
      OP_ADD: begin
        r   = sum[WIDTH-1:0];
        c_c = sum[WIDTH];
        v_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r   = sum[WIDTH-1:0];
        c_c = sum[WIDTH];
        v_c = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  r = xor_y;
      OP_ANDN: r = a & ~b;
      OP_ROL:  r = rol_y;
      OP_SLL:  r = sll_y;
      OP_ROR:  r = ror_y;
      OP_SRA:  r = sra_y;
      default: r = '0;
    endcase
  end

  // Flag packing.
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (r == '0);
    flags[FLAG_N] = r[WIDTH-1];
    flags[FLAG_V] = v_c;
    flags[FLAG_C] = c_c;
  end

endmodule

// File: rtl/alu_xor16.sv
// 16-bit bitwise XOR block.
module alu_xor16
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: valid/ready handshake around alu_core with a one-deep output register.
module ex_alu_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] flags
);

  logic [WIDTH-1:0]   core_r;
  logic [FLAGS_W-1:0] core_flags;
  logic               accept;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q,    result_d;
  logic [FLAGS_W-1:0] flags_q,     flags_d;

  alu_core u_core (
    .op    (op),
    .a     (A),
    .b     (B),
    .r     (core_r),
    .flags (core_flags)
  );

  // Ready whenever the register is empty or is being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next state: load on accept, clear valid on drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_r;
      flags_d     = core_flags;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed vectors, handshake sequences, randomized model check.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;

  ex_alu_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_r;
    logic [3:0]  exp_f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions: returns {result, Z, N, V, C}.
  function automatic logic [19:0] model(input int o, input int a, input int b);
    int r, c, v, k, sa, sb, ss;
    c = 0; v = 0; k = b & 15;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    case (o)
      0: begin r = a + b; c = (r >> 16) & 1; ss = sa + sb; v = (ss > 32767 || ss < -32768) ? 1 : 0; end
      1: begin r = a + ((~b) & 'hFFFF) + 1; c = (r >> 16) & 1; ss = sa - sb;
               v = (ss > 32767 || ss < -32768) ? 1 : 0; end
      2: r = a ^ b;
      3: r = a & ((~b) & 'hFFFF);
      4: r = (a << k) | (a >> (16 - k));
      5: r = a << k;
      6: r = (a >> k) | (a << (16 - k));
      default: r = sa >>> k;
    endcase
    r = r & 'hFFFF;
    return {r[15:0], (r == 0) ? 1'b1 : 1'b0, r[15], v[0], c[0]};
  endfunction

  vec_t vecs[$];
  logic [19:0] sb_q[$];

  initial begin
    logic [19:0] m;
    bit acc, drn, exp_rdy;

    vecs.push_back('{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110});
    vecs.push_back('{3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b1001});
    vecs.push_back('{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001});
    vecs.push_back('{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100});
    vecs.push_back('{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011});
    vecs.push_back('{3'b010, 16'hA5A5, 16'h0FF0, 16'hAA55, 4'b0100});
    vecs.push_back('{3'b011, 16'hFFFF, 16'h00FF, 16'hFF00, 4'b0100});
    vecs.push_back('{3'b100, 16'h8001, 16'h0001, 16'h0003, 4'b0000});
    vecs.push_back('{3'b110, 16'h0003, 16'h0001, 16'h8001, 4'b0100});
    vecs.push_back('{3'b111, 16'h8000, 16'h000F, 16'hFFFF, 4'b0100});
    vecs.push_back('{3'b101, 16'h1234, 16'h0000, 16'h1234, 4'b0000});
    vecs.push_back('{3'b101, 16'h00F1, 16'h0004, 16'h0F10, 4'b0000});
    vecs.push_back('{3'b100, 16'hBEEF, 16'h0010, 16'hBEEF, 4'b0100});

    // Reset held two cycles with in_valid asserted.
    rst_n = 1'b0; in_valid = 1'b1; op = 3'b000; A = 16'h0001; B = 16'h0001; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_flags", 32'(flags), 0);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 1);

    // Directed vectors, one op at a time.
    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = 1'b1; op = vecs[i].op; A = vecs[i].a; B = vecs[i].b; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp_r));
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_f));
      @(posedge clk);
    end

    // Back-pressure: X stalls 3 cycles while Y waits.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b000; A = 16'h0010; B = 16'h0020; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    op = 3'b001; A = 16'h0030; B = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_result", 32'(result), 32'h30);
      chk("bp_flags", 32'(flags), 0);
      #1 chk("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk); @(negedge clk);
    end
    chk("bp_hold_result", 32'(result), 32'h30);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 1);
    @(posedge clk); @(negedge clk);
    chk("bp_y_valid", 32'(out_valid), 1);
    chk("bp_y_result", 32'(result), 32'h20);
    chk("bp_y_flags", 32'(flags), 32'h1);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("bp_drained", 32'(out_valid), 0);
    chk("bp_retained", 32'(result), 32'h20);

    // Streaming eight back-to-back ADDs.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        chk("stream_valid", 32'(out_valid), 1);
        chk("stream_result", 32'(result), 32'(2 * (i - 1)));
      end
      in_valid = 1'b1; op = 3'b000; A = 16'(i); B = 16'(i); out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk("stream_valid_last", 32'(out_valid), 1);
    chk("stream_result_last", 32'(result), 32'd14);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset while stalled discards the held result.
    in_valid = 1'b1; op = 3'b000; A = 16'h0003; B = 16'h0004; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("mrst_pre_valid", 32'(out_valid), 1);
    chk("mrst_pre_result", 32'(result), 32'h7);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_result", 32'(result), 0);
    chk("mrst_flags", 32'(flags), 0);
    rst_n = 1'b1; in_valid = 1'b1; op = 3'b011; A = 16'hF0F0; B = 16'h00FF; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("mrst_after_valid", 32'(out_valid), 1);
    chk("mrst_after_result", 32'(result), 32'hF000);
    chk("mrst_after_flags", 32'(flags), 32'h4);
    @(posedge clk); @(negedge clk);

    // Randomized traffic against the scoreboard model.
    sb_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rand_valid", 32'(out_valid), (sb_q.size() != 0) ? 1 : 0);
      if (sb_q.size() != 0) begin
        chk("rand_result", 32'(result), 32'(sb_q[0][19:4]));
        chk("rand_flags", 32'(flags), 32'(sb_q[0][3:0]));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      op = 3'($urandom_range(0, 7));
      A  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: B = 16'($urandom_range(0, 15));
        1: B = A;
        default: B = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) A = 16'h8000;
      exp_rdy = (sb_q.size() == 0) || out_ready;
      #1 chk("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
      drn = (sb_q.size() != 0) && out_ready;
      acc = in_valid && exp_rdy;
      if (drn) void'(sb_q.pop_front());
      if (acc) begin
        m = model(int'(op), int'(A), int'(B));
        sb_q.push_back(m);
      end
      @(posedge clk); @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
